// File: rtl/sfc_output_collector_if.sv
// sfc_output_collector_if
//   Groups the frame control, input beat stream and write-request bus of the
//   SFC output collector.
//   master : the side that supplies start/frame geometry, beats and wr_ready
//   slave  : the collector itself
// Signals
//   start, m, n, base_addr        frame start pulse and geometry (sampled on start)
//   in_valid/in_ready/in_x/in_y/in_data   input beat handshake
//   wr_en/wr_ready/wr_addr/wr_data        write request handshake
//   frame_done, order_err, pix_count      frame status
interface sfc_output_collector_if #(
    parameter int DATA_WIDTH = 15,
    parameter int PIX_WIDTH  = 8,
    parameter int ADDR_WIDTH = 32
);
    logic                      start;
    logic [DATA_WIDTH:0]       m;
    logic [DATA_WIDTH:0]       n;
    logic [ADDR_WIDTH-1:0]     base_addr;
    logic                      in_valid;
    logic                      in_ready;
    logic [DATA_WIDTH:0]       in_x;
    logic [DATA_WIDTH:0]       in_y;
    logic [PIX_WIDTH-1:0]      in_data;
    logic                      wr_en;
    logic                      wr_ready;
    logic [ADDR_WIDTH-1:0]     wr_addr;
    logic [PIX_WIDTH-1:0]      wr_data;
    logic                      frame_done;
    logic                      order_err;
    logic [2*DATA_WIDTH+1:0]   pix_count;

    modport master (
        output start, m, n, base_addr, in_valid, in_x, in_y, in_data, wr_ready,
        input  in_ready, wr_en, wr_addr, wr_data, frame_done, order_err, pix_count
    );

    modport slave (
        input  start, m, n, base_addr, in_valid, in_x, in_y, in_data, wr_ready,
        output in_ready, wr_en, wr_addr, wr_data, frame_done, order_err, pix_count
    );
endinterface

// File: rtl/sfc_output_collector.sv
// sfc_output_collector
//   Consumer end of the SFC coordinate stream. Beats arrive in raster order
//   (x fastest). Each beat is checked against the expected coordinate; a
//   matching beat becomes one write to base_addr + running pixel offset (the
//   offset is a counter, so no multiplier is needed). Flags end of frame and
//   out-of-order coordinates.
// Ports
//   clk   clock, all state on posedge
//   rst   asynchronous active-high reset
//   bus   sfc_output_collector_if.slave (control, input beats, write bus, status)
module sfc_output_collector #(
    parameter int DATA_WIDTH = 15,
    parameter int PIX_WIDTH  = 8,
    parameter int ADDR_WIDTH = 32
) (
    input  logic clk,
    input  logic rst,
    sfc_output_collector_if.slave bus
);
    localparam int CW = DATA_WIDTH + 1;
    localparam int OW = 2 * DATA_WIDTH + 2;

    typedef enum logic [2:0] {IDLE, RUN, LAST, DONE, ERR} state_t;

    state_t                state;
    logic [CW-1:0]         ex, ey, m_r, n_r;
    logic [ADDR_WIDTH-1:0] base_r;
    logic [OW-1:0]         offset;
    logic                  wr_en_q;
    logic [ADDR_WIDTH-1:0] wr_addr_q;
    logic [PIX_WIDTH-1:0]  wr_data_q;
    logic                  frame_done_q, order_err_q;
    logic [OW-1:0]         pix_cnt;

    logic in_ready, accept, hit, last_pix, wr_hs;

    // A new beat may only enter when the output register is free or draining
    // this cycle, so a stalled write never gets overwritten.
    always_comb begin
        in_ready = (state == RUN) && (!wr_en_q || bus.wr_ready);
        accept   = bus.in_valid && in_ready;
        hit      = (bus.in_x == ex) && (bus.in_y == ey);
        last_pix = (ex == n_r) && (ey == m_r);
        wr_hs    = wr_en_q && bus.wr_ready;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            ex           <= '0;
            ey           <= '0;
            m_r          <= '0;
            n_r          <= '0;
            base_r       <= '0;
            offset       <= '0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            frame_done_q <= 1'b0;
            order_err_q  <= 1'b0;
            pix_cnt      <= '0;
        end else begin
            // Write drain; a same-cycle accept below re-arms wr_en.
            if (wr_hs) begin
                wr_en_q <= 1'b0;
                pix_cnt <= pix_cnt + OW'(1);
            end

            case (state)
                IDLE, DONE, ERR: begin
                    if (bus.start) begin
                        m_r          <= bus.m;
                        n_r          <= bus.n;
                        base_r       <= bus.base_addr;
                        ex           <= '0;
                        ey           <= '0;
                        offset       <= '0;
                        pix_cnt      <= '0;
                        frame_done_q <= 1'b0;
                        order_err_q  <= 1'b0;
                        state        <= RUN;
                    end
                end
                RUN: begin
                    if (accept) begin
                        if (hit) begin
                            wr_en_q   <= 1'b1;
                            wr_addr_q <= base_r + ADDR_WIDTH'(offset);
                            wr_data_q <= bus.in_data;
                            offset    <= offset + OW'(1);
                            if (ex == n_r) begin
                                ex <= '0;
                                ey <= ey + CW'(1);
                            end else begin
                                ex <= ex + CW'(1);
                            end
                            if (last_pix) state <= LAST;
                        end else begin
                            // Beat consumed, no write; pending write still drains.
                            order_err_q <= 1'b1;
                            state       <= ERR;
                        end
                    end
                end
                LAST: begin
                    if (wr_hs) begin
                        frame_done_q <= 1'b1;
                        state        <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready   = in_ready;
    assign bus.wr_en      = wr_en_q;
    assign bus.wr_addr    = wr_addr_q;
    assign bus.wr_data    = wr_data_q;
    assign bus.frame_done = frame_done_q;
    assign bus.order_err  = order_err_q;
    assign bus.pix_count  = pix_cnt;
endmodule

// File: tb/tb_sfc_output_collector.sv
module tb_sfc_output_collector;
    localparam int DW = 15;
    localparam int PW = 8;
    localparam int AW = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sfc_output_collector_if #(.DATA_WIDTH(DW), .PIX_WIDTH(PW), .ADDR_WIDTH(AW)) bus ();

    sfc_output_collector #(.DATA_WIDTH(DW), .PIX_WIDTH(PW), .ADDR_WIDTH(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    logic [AW+PW-1:0] obs_q [$];
    logic [AW+PW-1:0] exp_q [$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Write monitor: records handshakes and checks that a stalled write holds
    // its address/data and blocks new input.
    logic             hold_pend = 1'b0;
    logic [AW+PW-1:0] hold_val;
    always @(negedge clk) begin
        if (!rst && hold_pend) begin
            checks++;
            assert ({bus.wr_en, bus.wr_addr, bus.wr_data} === {1'b1, hold_val}) else begin
                errors++;
                $error("FAIL wr_hold: got %b/0x%0h want 1/0x%0h", bus.wr_en,
                       {bus.wr_addr, bus.wr_data}, hold_val);
            end
        end
        hold_pend = 1'b0;
        if (!rst && bus.wr_en) begin
            if (bus.wr_ready) begin
                obs_q.push_back({bus.wr_addr, bus.wr_data});
            end else begin
                hold_pend = 1'b1;
                hold_val  = {bus.wr_addr, bus.wr_data};
                checks++;
                assert (bus.in_ready === 1'b0) else begin
                    errors++;
                    $error("FAIL stall_in_ready: got %b expected 0", bus.in_ready);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_frame(input int mm, input int nn, input logic [AW-1:0] bb);
        bus.start     = 1'b1;
        bus.m         = mm[DW:0];
        bus.n         = nn[DW:0];
        bus.base_addr = bb;
        tick();
        bus.start     = 1'b0;
    endtask

    task automatic set_beat(input int x, input int y, input logic [PW-1:0] d);
        bus.in_x    = x[DW:0];
        bus.in_y    = y[DW:0];
        bus.in_data = d;
    endtask

    // mode 0: always valid/ready; 1: random valid/ready; 2: 3-cycle stall at 2nd write
    task automatic run_frame(input int mm, input int nn, input logic [AW-1:0] bb,
                             input int mode, input bit seq);
        int total, k, budget, stall_left, w;
        bit acc, stalled;
        logic [PW-1:0] pix [$];
        total = (mm + 1) * (nn + 1);
        pix.delete();
        exp_q.delete();
        obs_q.delete();
        for (int i = 0; i < total; i++) pix.push_back(seq ? PW'(i + 1) : PW'($urandom));
        // Reference: pixel (x,y) lands at base + y*(n+1) + x, modulo 2^AW.
        for (int y = 0; y <= mm; y++)
            for (int x = 0; x <= nn; x++)
                exp_q.push_back({bb + AW'(y * (nn + 1) + x), pix[y * (nn + 1) + x]});

        start_frame(mm, nn, bb);
        chk("start_pix_count", bus.pix_count, 0);
        chk("start_order_err", bus.order_err, 0);
        chk("start_frame_done", bus.frame_done, 0);

        k = 0; budget = 0; stall_left = (mode == 2) ? 3 : 0;
        while (k < total && budget < 2000) begin
            stalled      = 1'b0;
            bus.in_valid = (mode == 1) ? ($urandom_range(3) != 0) : 1'b1;
            set_beat(k % (nn + 1), k / (nn + 1), pix[k]);
            if (mode == 1) begin
                bus.wr_ready = ($urandom_range(3) != 0);
            end else if (mode == 2 && bus.wr_en && obs_q.size() == 1 && stall_left > 0) begin
                bus.wr_ready = 1'b0;
                stall_left--;
                stalled = 1'b1;
            end else begin
                bus.wr_ready = 1'b1;
            end
            @(negedge clk);
            acc = bus.in_valid && bus.in_ready;
            if (stalled) begin
                chk("stall_addr", bus.wr_addr, bb + 1);
                chk("stall_ready", bus.in_ready, 0);
            end
            tick();
            if (acc) k++;
            budget++;
        end
        chk("stream_accepted", k, total);
        bus.in_valid = 1'b0;
        bus.wr_ready = 1'b1;

        w = 0;
        while (obs_q.size() < total && w < 50) begin
            @(negedge clk);
            #1;
            w++;
        end
        chk("write_count", obs_q.size(), total);
        chk("done_not_early", bus.frame_done, 0);
        @(negedge clk);
        chk("frame_done", bus.frame_done, 1);
        chk("pix_count", bus.pix_count, total);
        chk("order_err", bus.order_err, 0);
        chk("done_in_ready", bus.in_ready, 0);
        for (int i = 0; i < total && i < obs_q.size(); i++)
            chk($sformatf("write[%0d]", i), obs_q[i], exp_q[i]);

        // A beat offered in DONE must stall, not be written.
        bus.in_valid = 1'b1;
        set_beat(0, 0, 8'hAA);
        repeat (3) begin
            @(negedge clk);
            chk("done_stall_ready", bus.in_ready, 0);
        end
        chk("done_no_write", obs_q.size(), total);
        bus.in_valid = 1'b0;
        tick();
    endtask

    initial begin
        bus.start = 1'b0; bus.m = '0; bus.n = '0; bus.base_addr = '0;
        bus.in_valid = 1'b0; bus.in_x = '0; bus.in_y = '0; bus.in_data = '0;
        bus.wr_ready = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", bus.in_ready, 0);
        chk("rst_wr_en", bus.wr_en, 0);
        chk("rst_frame_done", bus.frame_done, 0);
        chk("rst_order_err", bus.order_err, 0);
        chk("rst_pix_count", bus.pix_count, 0);
        chk("rst_wr_addr", bus.wr_addr, 0);
        rst = 1'b0;
        tick();
        chk("idle_in_ready", bus.in_ready, 0);

        // 1. nominal 3x2 frame, data 1..6
        run_frame(1, 2, 32'h100, 0, 1'b1);
        // 2. same frame, 3-cycle stall on the 2nd write
        run_frame(1, 2, 32'h100, 2, 1'b1);

        // 3. out-of-order coordinate
        start_frame(1, 1, 32'h2000);
        obs_q.delete();
        bus.wr_ready = 1'b1;
        bus.in_valid = 1'b1;
        set_beat(0, 0, 8'h5A);
        @(negedge clk);
        chk("err_first_ready", bus.in_ready, 1);
        tick();
        set_beat(0, 1, 8'hC3);
        @(negedge clk);
        chk("err_second_ready", bus.in_ready, 1);
        tick();
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("err_order_err", bus.order_err, 1);
        chk("err_in_ready", bus.in_ready, 0);
        chk("err_wr_en", bus.wr_en, 0);
        chk("err_frame_done", bus.frame_done, 0);
        repeat (3) @(negedge clk);
        chk("err_write_count", obs_q.size(), 1);
        if (obs_q.size() > 0) chk("err_write0", obs_q[0], {32'h2000, 8'h5A});
        chk("err_pix_count", bus.pix_count, 1);
        chk("err_sticky", bus.order_err, 1);
        tick();
        // restart from ERR clears order_err and runs cleanly
        run_frame(1, 1, 32'h3000, 0, 1'b0);

        // 4. degenerate 1x1 frame and address wrap
        run_frame(0, 0, 32'hFFFF_FFFF, 0, 1'b0);
        run_frame(0, 1, 32'hFFFF_FFFF, 0, 1'b0);

        // randomized frames with random valid/ready
        repeat (5) run_frame($urandom_range(3), $urandom_range(4), $urandom, 1, 1'b0);

        // 5. asynchronous reset mid-frame with a write pending
        start_frame(2, 2, 32'h500);
        bus.wr_ready = 1'b1;
        bus.in_valid = 1'b1;
        set_beat(0, 0, 8'h11);
        tick();
        set_beat(1, 0, 8'h22);
        tick();
        bus.in_valid = 1'b0;
        bus.wr_ready = 1'b0;
        chk("pre_rst_wr_en", bus.wr_en, 1);
        chk("pre_rst_pix_count", bus.pix_count, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_wr_en", bus.wr_en, 0);
        chk("async_rst_in_ready", bus.in_ready, 0);
        chk("async_rst_pix_count", bus.pix_count, 0);
        tick();
        rst = 1'b0;
        tick();
        chk("post_rst_idle_ready", bus.in_ready, 0);
        run_frame(2, 2, 32'h500, 1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
